// File: rtl/sobel_window_buffer.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel stage: two line buffers plus a shift window.
// Optional build macro COORD_OUT_EN adds the WinCol/WinRow centre-coordinate outputs.
module sobel_window_buffer #(
    parameter int IMG_WIDTH  = 256,
    parameter int IMG_HEIGHT = 256,
    parameter int PIX_BITS   = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  FrameStart,
    input  logic                  PixelValid,
    input  logic [PIX_BITS-1:0]   PixelIn,
    output logic [9*PIX_BITS-1:0] Window,
    output logic                  WindowValid,
`ifdef COORD_OUT_EN
    output logic [11:0]           WinCol,
    output logic [11:0]           WinRow,
`endif
    output logic                  FrameDone
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       col, col_eff;
    logic [RW-1:0]       row, row_eff;
    logic                accept, last_col, last_pix;

    logic [PIX_BITS-1:0] line_a [IMG_WIDTH];
    logic [PIX_BITS-1:0] line_b [IMG_WIDTH];
    logic [PIX_BITS-1:0] win_p1 [3][3];
    logic                vld_p1, done_p1;

    // A FrameStart pixel is always taken as (0,0), whatever the counters hold.
    always_comb begin
        col_eff  = FrameStart ? '0 : col;
        row_eff  = FrameStart ? '0 : row;
        accept   = PixelValid && (FrameStart || state == FILL || state == STREAM);
        last_col = (col_eff == CW'(IMG_WIDTH - 1));
        last_pix = last_col && (row_eff == RW'(IMG_HEIGHT - 1));
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            line_b[col_eff] <= line_a[col_eff];
            line_a[col_eff] <= PixelIn;
        end
    end

    // Stage p1: window shift, strobes and raster position
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_p1[r][c] <= '0;
`ifdef COORD_OUT_EN
            WinCol  <= '0;
            WinRow  <= '0;
`endif
        end else begin
            vld_p1  <= accept && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
            done_p1 <= accept && last_pix;
            if (FrameStart)
                state <= FILL;
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_p1[r][0] <= win_p1[r][1];
                    win_p1[r][1] <= win_p1[r][2];
                end
                win_p1[0][2] <= line_b[col_eff];
                win_p1[1][2] <= line_a[col_eff];
                win_p1[2][2] <= PixelIn;
`ifdef COORD_OUT_EN
                if ((row_eff >= RW'(2)) && (col_eff >= CW'(2))) begin
                    WinCol <= 12'(col_eff - CW'(1));
                    WinRow <= 12'(row_eff - RW'(1));
                end
`endif
                if (last_pix) begin
                    col   <= '0;
                    row   <= '0;
                    state <= DONE;
                end else if (last_col) begin
                    col <= '0;
                    row <= row_eff + RW'(1);
                    if (row_eff == RW'(1))
                        state <= STREAM;
                end else begin
                    col <= col_eff + CW'(1);
                    row <= row_eff;
                end
            end else if (FrameStart) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign Window[PIX_BITS*(3*r+c) +: PIX_BITS] = win_p1[r][c];
        end
    end

    assign WindowValid = vld_p1;
    assign FrameDone   = done_p1;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on a 4x3 image with a scoreboard of expected windows.
// Build with COORD_OUT_EN defined to also check the centre-coordinate outputs.
module tb_sobel_window_buffer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int P = 8;

    logic           CLK = 1'b0;
    logic           Reset, FrameStart, PixelValid;
    logic [P-1:0]   PixelIn;
    logic [9*P-1:0] Window;
    logic           WindowValid, FrameDone;
`ifdef COORD_OUT_EN
    logic [11:0]    WinCol, WinRow;
`endif

    sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_BITS(P)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .FrameStart(FrameStart),
        .PixelValid(PixelValid),
        .PixelIn(PixelIn),
        .Window(Window),
        .WindowValid(WindowValid),
`ifdef COORD_OUT_EN
        .WinCol(WinCol),
        .WinRow(WinRow),
`endif
        .FrameDone(FrameDone)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [9*P-1:0] win;
        logic           done;
        logic [11:0]    wc;
        logic [11:0]    wr;
    } exp_t;

    exp_t           q[$];
    logic [9*P-1:0] obs[$];
    int             tests = 0;
    int             fails = 0;
    int             nwin  = 0;
    bit             mon_en = 0;

    int img [H][W];
    bit m_act = 0;
    int mc = 0, mr = 0;

    task automatic chk(input string tag, input logic [9*P-1:0] o, input logic [9*P-1:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [9*P-1:0] pk(input int b);
        int t[9];
        logic [9*P-1:0] v;
        t = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        for (int k = 0; k < 9; k++) v[P*k +: P] = P'(t[k] + b);
        return v;
    endfunction

    // Drive one cycle and advance the reference raster model.
    task automatic step(input bit fs, input bit pv, input int val);
        exp_t e;
        @(negedge CLK);
        FrameStart = fs;
        PixelValid = pv;
        PixelIn    = P'(val);
        if (fs) begin
            m_act = 1; mc = 0; mr = 0;
        end
        if (pv && m_act) begin
            img[mr][mc] = val;
            if (mr >= 2 && mc >= 2) begin
                for (int k = 0; k < 9; k++)
                    e.win[P*k +: P] = P'(img[mr-2+k/3][mc-2+k%3]);
                e.done = (mr == H-1 && mc == W-1);
                e.wc   = 12'(mc - 1);
                e.wr   = 12'(mr - 1);
                q.push_back(e);
            end
            if (mr == H-1 && mc == W-1) begin
                m_act = 0; mc = 0; mr = 0;
            end else if (mc == W-1) begin
                mc = 0; mr++;
            end else begin
                mc++;
            end
        end
    endtask

    task automatic frame(input int base, input bit bubbles);
        step(1, 1, base);
        for (int i = 1; i < W*H; i++) begin
            if (bubbles)
                repeat ($urandom_range(0, 2)) step(0, 0, 0);
            step(0, 1, base + i);
        end
        repeat (3) step(0, 0, 0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (mon_en) begin
            if (WindowValid) begin
                nwin++;
                obs.push_back(Window);
                tests++;
                assert (q.size() > 0) else begin
                    fails++;
                    $error("FAIL unexpected_window observed=%0h expected=none", Window);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("window", Window, e.win);
                    chk("framedone", (9*P)'(FrameDone), (9*P)'(e.done));
`ifdef COORD_OUT_EN
                    chk("wincol", (9*P)'(WinCol), (9*P)'(e.wc));
                    chk("winrow", (9*P)'(WinRow), (9*P)'(e.wr));
`endif
                end
            end else begin
                chk("framedone_idle", (9*P)'(FrameDone), '0);
            end
        end
    end

    initial begin
        Reset = 1'b1; FrameStart = 1'b0; PixelValid = 1'b0; PixelIn = '0;
        repeat (2) @(negedge CLK);
        chk("reset_window", Window, '0);
        chk("reset_valid", (9*P)'(WindowValid), '0);
        chk("reset_done", (9*P)'(FrameDone), '0);
`ifdef COORD_OUT_EN
        chk("reset_wincol", (9*P)'(WinCol), '0);
        chk("reset_winrow", (9*P)'(WinRow), '0);
`endif
        Reset  = 1'b0;
        mon_en = 1;

        // Basic contiguous frame
        nwin = 0; obs.delete();
        frame(0, 0);
        chk("basic_count", (9*P)'(nwin), (9*P)'(2));
        if (obs.size() >= 2) begin
            chk("basic_win0", obs[0], pk(0));
            chk("basic_win1", obs[1], pk(1));
        end

        // DONE lockout, then a new frame
        nwin = 0; obs.delete();
        repeat (5) step(0, 1, 77);
        repeat (2) step(0, 0, 0);
        chk("lockout_count", (9*P)'(nwin), '0);
        frame(100, 0);
        chk("after_lockout_count", (9*P)'(nwin), (9*P)'(2));
        if (obs.size() >= 1) chk("after_lockout_win0", obs[0], pk(100));

        // Same frame with random bubbles
        nwin = 0; obs.delete();
        frame(0, 1);
        chk("bubble_count", (9*P)'(nwin), (9*P)'(2));
        if (obs.size() >= 2) begin
            chk("bubble_win0", obs[0], pk(0));
            chk("bubble_win1", obs[1], pk(1));
        end

        // Mid-frame restart after 7 pixels
        nwin = 0; obs.delete();
        step(1, 1, 200);
        for (int i = 1; i < 7; i++) step(0, 1, 200 + i);
        frame(50, 0);
        chk("restart_count", (9*P)'(nwin), (9*P)'(2));
        if (obs.size() >= 2) begin
            chk("restart_win0", obs[0], pk(50));
            chk("restart_win1", obs[1], pk(51));
        end

        // Reset in STREAM right after pixel 10
        nwin = 0; obs.delete();
        step(1, 1, 0);
        for (int i = 1; i <= 10; i++) step(0, 1, i);
        @(negedge CLK);
        Reset = 1'b1; FrameStart = 1'b0; PixelValid = 1'b0; m_act = 0;
        @(negedge CLK);
        chk("midreset_window", Window, '0);
        chk("midreset_valid", (9*P)'(WindowValid), '0);
        chk("midreset_done", (9*P)'(FrameDone), '0);
`ifdef COORD_OUT_EN
        chk("midreset_wincol", (9*P)'(WinCol), '0);
        chk("midreset_winrow", (9*P)'(WinRow), '0);
`endif
        Reset = 1'b0;
        for (int i = 0; i < W*H; i++) step(0, 1, 30 + i);
        repeat (3) step(0, 0, 0);
        chk("midreset_count", (9*P)'(nwin), (9*P)'(1));
        chk("queue_drained", (9*P)'(q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
